// File: rtl/pwm_multi_ctrl.sv
// rtl/pwm_multi_ctrl.sv - N-channel PWM generator with receiver pulse capture and pad mux
//
// Purpose:
//   Shared period counter drives NCH system PWM outputs.
//   Period and duty are double-buffered and applied only at a period boundary.
//   Each receiver input is synchronized and its high time is measured.
//   A sticky flag reports a lost input.
//   Each pad selects system PWM or raw receiver pass-through.
//
// Optional feature (macro PWM_MULTI_FAILSAFE_EN):
//   A selected pass-through falls back to system PWM while that channel's
//   timeout flag is set.
//
// Ports:
//   axi_clk, axi_rstn    clock, asynchronous active-low reset
//   pwm_enable_i         generator enable
//   pwm_period_i         period in cycles
//   pwm_active_i         per-channel high time, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//   pwm_update_i         request to load the shadow registers at the next wrap
//   pwm_update_pend_o    load pending
//   period_start_o       pulse in the cycle the counter is 0 after a wrap
//   pwm_mux_sel_i        1 = receiver pass-through, 0 = system PWM
//   pwm_pad_i            asynchronous receiver inputs
//   pwm_pad_o            pad outputs
//   meas_width_o         last measured high time per channel
//   meas_valid_o         pulse when meas_width_o updates
//   meas_timeout_o       sticky input-lost flag per channel
module pwm_multi_ctrl #(
  parameter int NCH         = 2,
  parameter int CNT_WIDTH   = 24,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 2500000
) (
  input  logic                     axi_clk,
  input  logic                     axi_rstn,
  input  logic                     pwm_enable_i,
  input  logic [CNT_WIDTH-1:0]     pwm_period_i,
  input  logic [NCH*CNT_WIDTH-1:0] pwm_active_i,
  input  logic                     pwm_update_i,
  output logic                     pwm_update_pend_o,
  output logic                     period_start_o,
  input  logic [NCH-1:0]           pwm_mux_sel_i,
  input  logic [NCH-1:0]           pwm_pad_i,
  output logic [NCH-1:0]           pwm_pad_o,
  output logic [NCH*CNT_WIDTH-1:0] meas_width_o,
  output logic [NCH-1:0]           meas_valid_o,
  output logic [NCH-1:0]           meas_timeout_o
);

  typedef logic [CNT_WIDTH-1:0] cnt_t;
  typedef enum logic {WAIT_RISE, HIGH} cap_state_e;

  localparam cnt_t CNT_ONE = cnt_t'(1);
  localparam cnt_t TMO_LIM = cnt_t'(TIMEOUT - 1);
  localparam cnt_t TMO_END = cnt_t'(TIMEOUT);

  // ---------------- generator ----------------
  cnt_t                     cnt_q, cnt_d;
  cnt_t                     period_sh_q, period_sh_d;
  logic [NCH*CNT_WIDTH-1:0] active_sh_q, active_sh_d;
  logic                     pend_q, pend_d;
  logic                     period_start_q, period_start_d;
  logic [NCH-1:0]           pwm_sys_q, pwm_sys_d;
  logic                     period_zero, wrap, load;

  always_comb begin
    period_zero = (period_sh_q == '0);
    wrap        = pwm_enable_i && !period_zero && (cnt_q == period_sh_q - CNT_ONE);
    // Disabled: shadows track the inputs.
    // Enabled: shadows load at a wrap, or immediately with a zero period
    // so a stopped generator can be restarted.
    load = !pwm_enable_i || ((pend_q || pwm_update_i) && (wrap || period_zero));

    period_sh_d    = load ? pwm_period_i : period_sh_q;
    active_sh_d    = load ? pwm_active_i : active_sh_q;
    pend_d         = load ? 1'b0 : (pend_q || pwm_update_i);
    cnt_d          = (!pwm_enable_i || period_zero || wrap) ? '0 : cnt_q + CNT_ONE;
    period_start_d = wrap;
    for (int i = 0; i < NCH; i++) begin
      pwm_sys_d[i] = pwm_enable_i && !period_zero &&
                     (cnt_q < active_sh_q[i*CNT_WIDTH +: CNT_WIDTH]);
    end
  end

  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      cnt_q          <= '0;
      period_sh_q    <= '0;
      active_sh_q    <= '0;
      pend_q         <= 1'b0;
      period_start_q <= 1'b0;
      pwm_sys_q      <= '0;
    end else begin
      cnt_q          <= cnt_d;
      period_sh_q    <= period_sh_d;
      active_sh_q    <= active_sh_d;
      pend_q         <= pend_d;
      period_start_q <= period_start_d;
      pwm_sys_q      <= pwm_sys_d;
    end
  end

  assign pwm_update_pend_o = pend_q;
  assign period_start_o    = period_start_q;

  // ---------------- per-channel capture and pad mux ----------------
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d, rise_q, rise_d, fall_q, fall_d;
    cap_state_e             st_q, st_d;
    cnt_t                   width_q, width_d, tmo_q, tmo_d, mw_q, mw_d;
    logic                   mv_q, mv_d, mt_q, mt_d;
    logic                   evt;

    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], pwm_pad_i[i]};
      dly_d  = sync_q[SYNC_STAGES-1];
      rise_d = sync_q[SYNC_STAGES-1] & ~dly_q;
      fall_d = ~sync_q[SYNC_STAGES-1] & dly_q;

      st_d    = st_q;
      width_d = width_q;
      mw_d    = mw_q;
      mv_d    = 1'b0;
      mt_d    = mt_q;
      // Timeout counter saturates one past the limit so the flag fires once.
      tmo_d   = (tmo_q == TMO_END) ? tmo_q : tmo_q + CNT_ONE;
      evt     = 1'b0;

      case (st_q)
        WAIT_RISE: begin
          if (rise_q) begin
            width_d = CNT_ONE;
            tmo_d   = '0;
            st_d    = HIGH;
            evt     = 1'b1;
          end
        end
        HIGH: begin
          if (fall_q) begin
            mw_d = width_q;
            mv_d = 1'b1;
            mt_d = 1'b0;
            st_d = WAIT_RISE;
            evt  = 1'b1;
          end else if (width_q != '1) begin
            width_d = width_q + CNT_ONE;
          end
        end
        default: st_d = WAIT_RISE;
      endcase

      // A real edge in the same cycle wins over the timeout.
      if (tmo_q == TMO_LIM && !evt) begin
        mt_d = 1'b1;
        st_d = WAIT_RISE;
      end
    end

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
      if (!axi_rstn) begin
        sync_q  <= '0;
        dly_q   <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        st_q    <= WAIT_RISE;
        width_q <= '0;
        tmo_q   <= '0;
        mw_q    <= '0;
        mv_q    <= 1'b0;
        mt_q    <= 1'b1;
      end else begin
        sync_q  <= sync_d;
        dly_q   <= dly_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
        st_q    <= st_d;
        width_q <= width_d;
        tmo_q   <= tmo_d;
        mw_q    <= mw_d;
        mv_q    <= mv_d;
        mt_q    <= mt_d;
      end
    end

    assign meas_width_o[i*CNT_WIDTH +: CNT_WIDTH] = mw_q;
    assign meas_valid_o[i]                        = mv_q;
    assign meas_timeout_o[i]                      = mt_q;

`ifdef PWM_MULTI_FAILSAFE_EN
    assign pwm_pad_o[i] = (pwm_mux_sel_i[i] && !mt_q) ? pwm_pad_i[i] : pwm_sys_q[i];
`else
    assign pwm_pad_o[i] = pwm_mux_sel_i[i] ? pwm_pad_i[i] : pwm_sys_q[i];
`endif
  end

endmodule

// File: doc/pwm_multi_ctrl.md
Name: pwm_multi_ctrl

Overview:
- N-channel successor of the two-channel drive/steer PWM path.
- Generates N PWM outputs from one shared period counter.
- Double-buffers period/duty so new values are applied glitch-free, only at a period boundary.
- Measures the high-time of each RF-receiver input pulse, with timeout detection, and muxes each pad between system PWM and receiver pass-through. Sits between the sys_ctrl AXI register block and the pads.

Parameters:
- NCH, 2, number of PWM channels (1..8).
- CNT_WIDTH, 24, width of the period, duty and measurement counters.
- SYNC_STAGES, 2, synchronizer flops on each pwm_pad_i (minimum 2).
- TIMEOUT, 2500000, cycles without a rising edge before the input is declared lost (must fit in CNT_WIDTH).

Ports:
- axi_clk  in  1  system clock.
- axi_rstn  in  1  asynchronous active-low reset.
- pwm_enable_i  in  1  generator enable.
- pwm_period_i  in  CNT_WIDTH  period in cycles.
- pwm_active_i  in  NCH*CNT_WIDTH  per-channel high time; channel i is at [i*CNT_WIDTH +: CNT_WIDTH].
- pwm_update_i  in  1  one-cycle request to load the shadow registers.
- pwm_update_pend_o  out  1  high while a load is pending.
- period_start_o  out  1  one-cycle pulse when the counter wraps to 0.
- pwm_mux_sel_i  in  NCH  1 = pass pwm_pad_i through to the pad, 0 = system PWM.
- pwm_pad_i  in  NCH  receiver inputs (asynchronous).
- pwm_pad_o  out  NCH  pad outputs.
- meas_width_o  out  NCH*CNT_WIDTH  last measured high time, in cycles.
- meas_valid_o  out  NCH  one-cycle pulse when meas_width_o updates.
- meas_timeout_o  out  NCH  sticky input-lost flag.

Behaviour:
- Reset values: counter, shadows, meas_width_o, meas_valid_o, pwm_update_pend_o, period_start_o and all synchronizers = 0; meas_timeout_o = all ones (no input seen yet); internal PWM = 0.
- Shadow registers:
  - While pwm_enable_i = 0, shadows load from the inputs every cycle and pend is cleared.
  - While enabled, pwm_update_i sets pend.
  - At the wrap cycle with pend = 1, shadows load and pend clears.
  - If pwm_update_i and wrap occur in the same cycle, the load happens at that wrap.
- Counter:
  - Disabled: cnt held at 0.
  - Enabled: cnt increments; when cnt == period_sh-1, next cnt = 0 and period_start_o pulses on the following cycle, aligned with cnt = 0.
  - period_sh = 0: cnt held at 0, no period_start_o pulses, all system PWM low. Shadows still load while pend, so the block can recover.
- System PWM: pwm_sys[i] registered = enable && period_sh != 0 && cnt < active_sh[i]; one cycle latency from cnt.
  - active_sh = 0 gives constant low.
  - active_sh >= period_sh gives constant high.
- Disable mid-period: PWM goes low the next cycle and the counter restarts from 0 on re-enable.
- Input capture, per channel: synchronizer, then registered edge detect. FSM per channel:
  - WAIT_RISE: on rise, width_cnt = 1, tmo_cnt = 0, go to HIGH.
  - HIGH: width_cnt increments, saturating at all ones. On fall, meas_width_o = width_cnt, meas_valid_o pulses, meas_timeout_o clears, go to WAIT_RISE.
- Timeout: tmo_cnt runs in both states and resets on each rise. When tmo_cnt reaches TIMEOUT, meas_timeout_o is set, the FSM returns to WAIT_RISE and meas_width_o is held.
- A fall without a prior rise (in WAIT_RISE) is ignored.
- Pad mux: pwm_pad_o[i] = pwm_mux_sel_i[i] ? pwm_pad_i[i] (raw, combinational) : pwm_sys[i].

Optional Feature:
- PWM_MULTI_FAILSAFE_EN defined: when pwm_mux_sel_i[i] = 1 and meas_timeout_o[i] = 1, pwm_pad_o[i] = pwm_sys[i]. Pass-through resumes combinationally once the flag clears (after the first valid measurement).
- Not defined: the mux is a pure select and meas_timeout_o is status only.

Test Plan:
- Reset with NCH = 2, period = 10, active = {3,7}, enable = 1. Required: pad0 high for 3 of every 10 cycles, pad1 high for 7 of every 10; period_start_o every 10 cycles; pend = 0.
- While running, set active0 = 5 and pulse pwm_update_i mid-period. Required: pad0 keeps 3-cycle highs until the next wrap, then 5-cycle highs; pend is high from the update until that wrap.
- active = 0 gives pad constant low; active = 12 with period 10 gives constant high; period = 0 gives all low and no period_start_o; enable dropped mid-period gives low next cycle.
- 1500-cycle high pulse on pwm_pad_i[1]. Required: meas_width_o[1] = 1500 and a single meas_valid_o[1] pulse, both exactly SYNC_STAGES+2 cycles after the falling pad edge; meas_timeout_o[1] = 0.
- TIMEOUT = 100, input held low for 150 cycles after a valid pulse. Required: meas_timeout_o set 100 cycles after the last rise; meas_width_o unchanged.
- With PWM_MULTI_FAILSAFE_EN defined, mux_sel = 2'b11 and no input activity. Required: pads carry the system PWM. After a valid pulse on channel 0, pad0 follows pwm_pad_i[0] while pad1 stays on the system PWM.
